// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and constants for the Gray counter slice.
// Functions work on GRAY_W_MAX-bit zero-extended values; callers size back.
package gray_pkg;

  localparam int GRAY_W_DEFAULT = 4;
  localparam int GRAY_W_MAX     = 32;

  typedef logic [GRAY_W_MAX-1:0] gvec_t;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_CLR   = 2'd1,
    OP_LOAD  = 2'd2,
    OP_COUNT = 2'd3
  } gray_op_e;

  function automatic gvec_t bin2gray(input gvec_t b);
    return b ^ (b >> 1);
  endfunction

  // True when exactly one bit differs between two adjacent Gray words.
  function automatic logic gray_popcount_one(input gvec_t x);
    return (x != '0) && ((x & (x - gvec_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/gray_code_counter_bin_to_gray.sv
// Combinational binary-to-Gray encoder; inverse of gray_to_binary.
// Ports: bin (WIDTH in), gray (WIDTH out). WIDTH <= GRAY_W_MAX.
module bin_to_gray
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W_DEFAULT
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  gvec_t bin_ext;
  gvec_t gray_ext;

  always_comb begin
    bin_ext  = gvec_t'(bin);
    gray_ext = bin2gray(bin_ext);
    gray     = gray_ext[WIDTH-1:0];
  end

endmodule

// File: rtl/gray_code_counter.sv
// Up/down binary counter with registered Gray image, wrap pulse and
// optional sticky adjacency checker (enable with GRAY_CNT_CHECK_EN).
// Ports: clk, rst_n, clr, load, load_bin, en, up -> bin, gray, wrap, err.
module gray_code_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] BIN_MAX = '1;
  localparam logic [WIDTH-1:0] BIN_ONE = WIDTH'(1);

  gray_op_e         op;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    op = OP_HOLD;
    if (clr)       op = OP_CLR;
    else if (load) op = OP_LOAD;
    else if (en)   op = OP_COUNT;
  end

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    unique case (op)
      OP_CLR:  bin_d = '0;
      OP_LOAD: bin_d = load_bin;
      OP_COUNT: begin
        if (up) begin
          bin_d  = bin_q + BIN_ONE;
          wrap_d = (bin_q == BIN_MAX);
        end else begin
          bin_d  = bin_q - BIN_ONE;
          wrap_d = (bin_q == '0);
        end
      end
      default: bin_d = bin_q;
    endcase
  end

  // Gray is encoded from the next value so it lands on the same edge as bin.
  bin_to_gray #(
    .WIDTH (WIDTH)
  ) u_enc (
    .bin  (bin_d),
    .gray (gray_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;
  assign wrap = wrap_q;

`ifdef GRAY_CNT_CHECK_EN
  logic [WIDTH-1:0] gray_prev_q, gray_prev_d;
  logic             step_q, step_d;
  logic             err_q, err_d;
  logic             adj_ok;

  always_comb begin
    adj_ok      = gray_popcount_one(gvec_t'(gray_prev_q ^ gray_q));
    step_d      = (op == OP_COUNT);
    gray_prev_d = gray_q;
    err_d       = err_q;
    if (clr)
      err_d = 1'b0;
    else if (step_q && !adj_ok)
      err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_prev_q <= '0;
      step_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      gray_prev_q <= gray_prev_d;
      step_q      <= step_d;
      err_q       <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_code_counter.sv
// Randomized scoreboard bench for gray_code_counter (WIDTH=4).
// Stimulus pushes model results; a monitor pops and compares each cycle.
module tb_gray_code_counter;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_bin = '0;
  logic         en = 1'b0;
  logic         up = 1'b0;
  logic [W-1:0] bin;
  logic [W-1:0] gray;
  logic         wrap;
  logic         err;

  typedef struct {
    int    b;
    int    g;
    bit    w;
    string tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   m_cnt = 0;

  gray_code_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .load     (load),
    .load_bin (load_bin),
    .en       (en),
    .up       (up),
    .bin      (bin),
    .gray     (gray),
    .wrap     (wrap),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reflected Gray code from its textbook definition.
  function automatic int gray_of(input int n);
    return n ^ (n >> 1);
  endfunction

  function automatic int gray_dec(input int g);
    int b = 0;
    for (int i = W - 1; i >= 0; i--)
      b |= (((b >> (i + 1)) & 1) ^ ((g >> i) & 1)) << i;
    return b;
  endfunction

  task automatic step(input bit c, input bit l, input int lb,
                      input bit e, input bit u, input string tag);
    exp_t x;
    bit   w;
    @(negedge clk);
    clr = c; load = l; load_bin = W'(lb); en = e; up = u;
    w = 1'b0;
    if (c) m_cnt = 0;
    else if (l) m_cnt = lb % MOD;
    else if (e) begin
      m_cnt = u ? m_cnt + 1 : m_cnt - 1;
      if (m_cnt >= MOD || m_cnt < 0) w = 1'b1;
      m_cnt = (m_cnt + MOD) % MOD;
    end
    x.b = m_cnt; x.g = gray_of(m_cnt); x.w = w; x.tag = tag;
    q.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clr = 0; load = 0; en = 0; up = 0;
    #1;
    chk("rst_bin", int'(bin), 0);
    chk("rst_gray", int'(gray), 0);
    chk("rst_wrap", int'(wrap), 0);
    chk("rst_err", int'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_cnt = 0;
  endtask

  // Monitor: one registered result per edge after each issued step.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk({x.tag, "_bin"}, int'(bin), x.b);
        chk({x.tag, "_gray"}, int'(gray), x.g);
        chk({x.tag, "_wrap"}, int'(wrap), int'(x.w));
        chk({x.tag, "_dec"}, gray_dec(int'(gray)), x.b);
        chk({x.tag, "_err"}, int'(err), 0);
      end
    end
  end

  initial begin
    int r;
    do_reset();

    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 1, "up16");
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, "idle");

    do_reset();
    step(0, 0, 0, 1, 0, "down_wrap");
    step(0, 0, 0, 1, 0, "down_next");

    step(0, 1, 5, 0, 0, "pri_pre");
    step(1, 1, 10, 1, 1, "pri_all");
    step(0, 1, 10, 0, 0, "pri_load");

    step(0, 1, 15, 0, 0, "bnd_pre");
    step(0, 1, 0, 1, 1, "bnd_load0");
    step(0, 0, 0, 1, 1, "bnd_up");
    step(1, 0, 0, 1, 0, "clr_en");

    do_reset();
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1, "to6");
    @(posedge clk);
    #2;
    chk("pre_async_bin", int'(bin), 6);
    rst_n = 1'b0;
    en = 1'b1; up = 1'b1;
    #1;
    chk("async_bin", int'(bin), 0);
    chk("async_gray", int'(gray), 0);
    chk("async_wrap", int'(wrap), 0);
    #1;
    rst_n = 1'b1;
    m_cnt = 0;
    step(0, 0, 0, 1, 1, "post_rst");

    for (int i = 0; i < 2000; i++) begin
      r = int'($urandom_range(0, 99));
      step(r < 3, (r >= 3) && (r < 10), int'($urandom_range(0, MOD - 1)),
           r >= 20 || ($urandom_range(0, 1) == 1), $urandom_range(0, 1) == 1,
           "rand");
    end

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    chk("final_err", int'(err), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
